fft_ctrl_seq: RTL and testbench

- Control sequencer for the 16-point radix-2 in-place FFT core.
- Sequences sample load, then drives the stage/butterfly index pair into the read-address LUT.
- Issues read strobes, then emits matching delayed write strobes and indices so write-back addresses come from the same LUT.
- Sequences result unload with a valid/ready handshake.

---
 rtl/fft_pkg.sv | 24 ++
 rtl/fft_wr_delay.sv | 26 ++
 rtl/fft_ctrl_seq.sv | 117 +++++++++++
 tb/tb_fft_ctrl_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, types and state encoding for the 16-point FFT control sequencer
package fft_pkg;
  localparam int FFT_N     = 16;
  localparam int FFT_LOG2N = 4;
  localparam int N_STAGES  = 4;
  localparam int N_BF      = 8;
  localparam int ADDR_W    = FFT_LOG2N;
  localparam int STAGE_W   = 2;
  localparam int BF_W      = 3;
  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [STAGE_W-1:0] stage_t;
  typedef logic [BF_W-1:0]    bf_t;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_FLUSH, S_UNLOAD} state_e;
  typedef struct packed {
    logic   v;
    stage_t s;
    bf_t    b;
  } wr_tag_t;
  function automatic addr_t bitrev(input addr_t a);
    addr_t r;
    for (int i = 0; i < ADDR_W; i++) r[i] = a[ADDR_W-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_wr_delay.sv
// fft_wr_delay: LAT-deep shift register aligning read tags {valid, stage, butterfly} with butterfly write-back
module fft_wr_delay
  import fft_pkg::*;
#(
  parameter int LAT = 3
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  input  stage_t in_stage,
  input  bf_t    in_bf,
  output logic   out_valid,
  output stage_t out_stage,
  output bf_t    out_bf
);
  wr_tag_t pipe_q [LAT];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= {in_valid, in_stage, in_bf};
      for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end
  assign {out_valid, out_stage, out_bf} = pipe_q[LAT-1];
endmodule

// File: rtl/fft_ctrl_seq.sv
// fft_ctrl_seq: load/run/flush/unload sequencer for the 16-point FFT; FFT_BITREV_OUT_EN selects bit-reversed unload order
module fft_ctrl_seq
  import fft_pkg::*;
#(
  parameter int BF_LATENCY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              load_we,
  output logic [ADDR_W-1:0] load_addr,
  output logic [1:0]        stage,
  output logic [2:0]        butterfly,
  output logic              rd_en,
  output logic              wr_en,
  output logic [1:0]        wr_stage,
  output logic [2:0]        wr_butterfly,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done
);
  state_e state_q, state_d;
  addr_t  cnt_q, cnt_d;
  stage_t stage_q, stage_d;
  bf_t    bf_q, bf_d;
  logic   done_q, done_d;
  logic   cnt_last;
  assign cnt_last = cnt_q == addr_t'(FFT_N - 1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    bf_d    = bf_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_LOAD;
        cnt_d   = '0;
      end
      S_LOAD: if (in_valid) begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_last) begin
          state_d = S_RUN;
          stage_d = '0;
          bf_d    = '0;
        end
      end
      S_RUN: begin
        bf_d = bf_q + 3'd1;
        if (bf_q == bf_t'(N_BF - 1)) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end
      end
      S_FLUSH: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == addr_t'(BF_LATENCY - 1)) begin
          cnt_d   = '0;
          state_d = stage_q == stage_t'(N_STAGES - 1) ? S_UNLOAD : S_RUN;
          stage_d = stage_q == stage_t'(N_STAGES - 1) ? stage_q : stage_q + 2'd1;
          bf_d    = '0;
        end
      end
      S_UNLOAD: if (out_ready) begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      stage_q <= '0;
      bf_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      bf_q    <= bf_d;
      done_q  <= done_d;
    end
  end
  assign in_ready  = state_q == S_LOAD;
  assign load_we   = in_ready && in_valid;
  assign load_addr = cnt_q;
  assign stage     = stage_q;
  assign butterfly = bf_q;
  assign rd_en     = state_q == S_RUN;
  assign out_valid = state_q == S_UNLOAD;
`ifdef FFT_BITREV_OUT_EN
  assign out_addr  = bitrev(cnt_q);
`else
  assign out_addr  = cnt_q;
`endif
  assign busy      = state_q != S_IDLE;
  assign done      = done_q;
  fft_wr_delay #(.LAT(BF_LATENCY)) u_wr_delay (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_en),
    .in_stage (stage_q),
    .in_bf    (bf_q),
    .out_valid(wr_en),
    .out_stage(wr_stage),
    .out_bf   (wr_butterfly)
  );
endmodule

// File: tb/tb_fft_ctrl_seq.sv
// tb_fft_ctrl_seq: self-checking bench for fft_ctrl_seq against a schedule-level reference model
module tb_fft_ctrl_seq;
  localparam int LAT = 3;
  localparam int STAGE_CYC = 8 + LAT;
  localparam int COMPUTE = 4 * STAGE_CYC;
  logic clk = 1'b0;
  logic rst, start, in_valid, out_ready;
  logic in_ready, load_we, rd_en, wr_en, out_valid, busy, done;
  logic [3:0] load_addr, out_addr;
  logic [1:0] stage, wr_stage;
  logic [2:0] butterfly, wr_butterfly;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [5:0] wq[$];
  int rev_tbl[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  always #5 clk = ~clk;
  fft_ctrl_seq #(.BF_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .load_we(load_we), .load_addr(load_addr), .stage(stage), .butterfly(butterfly),
    .rd_en(rd_en), .wr_en(wr_en), .wr_stage(wr_stage), .wr_butterfly(wr_butterfly),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .busy(busy), .done(done)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask
  task automatic tick();
    logic was_rst;
    logic [5:0] exp_wr;
    was_rst = rst;
    @(posedge clk);
    #1;
    cyc++;
    if (was_rst) begin
      exp_wr = '0;
      wq.delete();
      repeat (LAT - 1) wq.push_back('0);
    end else begin
      exp_wr = wq.pop_front();
    end
    wq.push_back({rd_en, stage, butterfly});
    chk("wr_delay", 32'({wr_en, wr_stage, wr_butterfly}), 32'(exp_wr));
  endtask
  task automatic all_zero();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_load_we", 32'(load_we), 0);
    chk("rst_load_addr", 32'(load_addr), 0);
    chk("rst_stage", 32'(stage), 0);
    chk("rst_butterfly", 32'(butterfly), 0);
    chk("rst_rd_en", 32'(rd_en), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_stage", 32'(wr_stage), 0);
    chk("rst_wr_butterfly", 32'(wr_butterfly), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_addr", 32'(out_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
  endtask
  task automatic load_phase(input int mode);
    int acc, g;
    bit v;
    acc = 0;
    g = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_busy", 32'(busy), 1);
    while (acc < 16 && g < 200) begin
      v = mode == 0 ? 1'b1 : mode == 1 ? (g % 2 == 0) : bit'($urandom_range(0, 1));
      in_valid = v;
      #1;
      chk("load_in_ready", 32'(in_ready), 1);
      chk("load_we", 32'(load_we), 32'(v));
      chk("load_addr", 32'(load_addr), 32'(acc));
      chk("load_rd_en", 32'(rd_en), 0);
      tick();
      acc += int'(v);
      g++;
    end
    in_valid = 1'b0;
    chk("load_accepts", 32'(acc), 16);
  endtask
  task automatic run_phase(input int n_end, input bit poke);
    bit rd_x, wr_x;
    for (int n = 0; n <= n_end; n++) begin
      rd_x = n < COMPUTE && n % STAGE_CYC < 8;
      wr_x = n >= LAT && n - LAT < COMPUTE && (n - LAT) % STAGE_CYC < 8;
      chk("run_rd_en", 32'(rd_en), 32'(rd_x));
      chk("run_out_valid", 32'(out_valid), 32'(n >= COMPUTE));
      chk("run_in_ready", 32'(in_ready), 0);
      chk("run_busy", 32'(busy), 1);
      if (rd_x) begin
        chk("run_stage", 32'(stage), 32'(n / STAGE_CYC));
        chk("run_butterfly", 32'(butterfly), 32'(n % STAGE_CYC));
      end
      chk("run_wr_en", 32'(wr_en), 32'(wr_x));
      if (wr_x) begin
        chk("run_wr_stage", 32'(wr_stage), 32'((n - LAT) / STAGE_CYC));
        chk("run_wr_butterfly", 32'(wr_butterfly), 32'((n - LAT) % STAGE_CYC));
      end
      if (n == n_end) break;
      start = poke && n >= 4 && n < 7;
      tick();
    end
    start = 1'b0;
  endtask
  task automatic unload_phase(input int mode);
    int acc, g, ea;
    bit r;
    acc = 0;
    g = 0;
    while (acc < 16 && g < 200) begin
      r = mode == 0 ? 1'b1 : mode == 1 ? (g % 3 == 0) : bit'($urandom_range(0, 1));
      out_ready = r;
      #1;
`ifdef FFT_BITREV_OUT_EN
      ea = rev_tbl[acc];
`else
      ea = acc;
`endif
      chk("unload_out_valid", 32'(out_valid), 1);
      chk("unload_out_addr", 32'(out_addr), 32'(ea));
      chk("unload_done", 32'(done), 0);
      chk("unload_busy", 32'(busy), 1);
      tick();
      acc += int'(r);
      g++;
    end
    out_ready = 1'b0;
    chk("unload_accepts", 32'(acc), 16);
    chk("done_pulse", 32'(done), 1);
    chk("busy_fall", 32'(busy), 0);
    chk("out_valid_fall", 32'(out_valid), 0);
    tick();
    chk("done_single", 32'(done), 0);
  endtask
  task automatic frame(input int in_mode, input int out_mode, input bit poke);
    load_phase(in_mode);
    run_phase(COMPUTE, poke);
    unload_phase(out_mode);
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    all_zero();
    rst = 1'b0;
    tick();
    tick();
    frame(0, 0, 1'b1);
    frame(1, 1, 1'b0);
    frame(2, 2, 1'b0);
    frame(2, 2, 1'b1);
    load_phase(0);
    run_phase(2 * STAGE_CYC + 3, 1'b0);
    chk("mid_stage", 32'(stage), 2);
    chk("mid_butterfly", 32'(butterfly), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    all_zero();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post_rst_wr_en", 32'(wr_en), 0);
      chk("post_rst_busy", 32'(busy), 0);
    end
    frame(0, 1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
